tree_adder_procedural: RTL and testbench
========================================

// Module: tree_adder_procedural
// PURPOSE
//   Two-level registered tree adder. Level 1 forms sum1 = a + b and sum2 = c + d
//   in parallel; level 2 forms sum3 = sum1 + sum2. All widths grow so no result
//   ever overflows. Small datapath leaf; results feed downstream accumulate/compare.
//   The same arithmetic is fully pipelined: one new operand set per clock.
// PARAMETERS
//   WAB   4   width of operands a, b (sum1 is WAB+1)
//   WCD   8   width of operands c, d (sum2 is WCD+1); WCD >= WAB required
// PORTS
//   clk       in   1        rising-edge clock, sole clock domain
//   rst_n     in   1        reset; synchronous and active-low
//   in_valid  in   1        a/b/c/d are valid this cycle
//   a         in   WAB      unsigned operand
//   b         in   WAB      unsigned operand
//   c         in   WCD      unsigned operand
//   d         in   WCD      unsigned operand
//   out_valid out  1        sum1/sum2/sum3 hold results of one operand set
//   sum1      out  WAB+1    a + b
//   sum2      out  WCD+1    c + d
//   sum3      out  WCD+2    (a + b) + (c + d)
// BEHAVIOUR
//   - Reset: while rst_n==0 at a rising edge, all pipeline and output regs
//     clear: out_valid=0, sum1=0, sum2=0, sum3=0. No async path.
//   - Unsigned arithmetic only; zero-extend each operand to the result width
//     before adding. No truncation anywhere: max 15+15=30, 255+255=510, 540 fits.
//   - Stage 1 (edge N): register s1=a+b, s2=c+d, v1=in_valid.
//   - Stage 2 (edge N+1): sum1<=s1, sum2<=s2, sum3<=s1+s2 (s1 zero-extended),
//     out_valid<=v1. Latency exactly 2 clocks; all three outputs time-aligned.
//   - Throughput 1/clock; no stall or backpressure; every edge advances the pipe.
//   - Data registers load every cycle regardless of in_valid; out_valid marks
//     meaningful results. Consumers must ignore sums when out_valid==0.
//   - Reset mid-stream discards in-flight sets: out_valid=0 the cycle after the
//     reset edge and stays 0 until 2 edges after first valid post-reset input.
//   - X on inputs with in_valid==0 must not corrupt out_valid.
//   - Operands with in_valid==1 on consecutive cycles yield results on
//     consecutive cycles, in order.
// TESTING
//   1. Reset: hold rst_n=0 for 3 clocks -> out_valid=0, sum1=sum2=sum3=0.
//   2. a=0,b=3,c=1,d=255 -> 2 clocks later sum1=3, sum2=256, sum3=259.
//   3. Back-to-back: (10,13,9,10),(15,15,109,37),(0,9,45,45) on successive
//      clocks -> (23,19,42),(30,146,176),(9,90,99) on successive clocks.
//   4. Max corner: a=b=15, c=d=255 -> sum1=30, sum2=510, sum3=540; min all 0 -> 0.
//   5. Bubble: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed 2 clocks.
//   6. Reset mid-stream: assert rst_n=0 with 2 sets in flight -> both dropped,
//      out_valid=0; next valid set appears exactly 2 clocks after its input.
//   Random: 10k constrained-random sets vs. reference model, check alignment.

Source files
------------

// File: rtl/tree_adder_procedural.sv
// Two-level registered tree adder: a+b and c+d in stage 1, their sum in stage 2.
// Fully pipelined, one operand set per clock, fixed two-clock latency.
module tree_adder_procedural #(
    parameter int WAB = 4,
    parameter int WCD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WAB-1:0]   a,
    input  logic [WAB-1:0]   b,
    input  logic [WCD-1:0]   c,
    input  logic [WCD-1:0]   d,
    output logic             out_valid,
    output logic [WAB:0]     sum1,
    output logic [WCD:0]     sum2,
    output logic [WCD+1:0]   sum3
);

    logic [WAB:0]   s1;
    logic [WCD:0]   s2;
    logic           v1;
    logic [WCD+1:0] s1_ext;
    logic [WCD+1:0] s2_ext;

    // Operands are widened before adding so no carry is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            v1 <= 1'b0;
        end else begin
            s1 <= {1'b0, a} + {1'b0, b};
            s2 <= {1'b0, c} + {1'b0, d};
            v1 <= in_valid;
        end
    end

    always_comb begin
        s1_ext = {{(WCD + 1 - WAB){1'b0}}, s1};
        s2_ext = {1'b0, s2};
    end

    // Data regs load every cycle; out_valid alone qualifies the sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum1      <= '0;
            sum2      <= '0;
            sum3      <= '0;
            out_valid <= 1'b0;
        end else begin
            sum1      <= s1;
            sum2      <= s2;
            sum3      <= s1_ext + s2_ext;
            out_valid <= v1;
        end
    end

endmodule

// File: tb/tb_tree_adder_procedural.sv
// Scoreboard bench for tree_adder_procedural: expected sums are queued when a
// valid set is driven and popped when out_valid is predicted two edges later.
module tb_tree_adder_procedural;

    localparam int WAB = 4;
    localparam int WCD = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WAB-1:0]   a = '0;
    logic [WAB-1:0]   b = '0;
    logic [WCD-1:0]   c = '0;
    logic [WCD-1:0]   d = '0;
    logic             out_valid;
    logic [WAB:0]     sum1;
    logic [WCD:0]     sum2;
    logic [WCD+1:0]   sum3;

    typedef struct packed {
        logic [WAB:0]   s1;
        logic [WCD:0]   s2;
        logic [WCD+1:0] s3;
    } result_t;

    result_t sbq[$];
    logic    ev1 = 1'b0;
    logic    ev2 = 1'b0;
    int      checks = 0;
    int      failures = 0;

    tree_adder_procedural #(.WAB(WAB), .WCD(WCD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .sum1      (sum1),
        .sum2      (sum2),
        .sum3      (sum3)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one cycle of inputs, queues the expected result of a valid set,
    // then advances the expected valid pipeline across the clock edge.
    task automatic step(input logic v, input logic [WAB-1:0] ia, input logic [WAB-1:0] ib,
                        input logic [WCD-1:0] ic, input logic [WCD-1:0] id, input logic rn);
        result_t r;
        in_valid = v;
        a = ia;
        b = ib;
        c = ic;
        d = id;
        rst_n = rn;
        if (v === 1'b1 && rn === 1'b1) begin
            r.s1 = (WAB+1)'(int'(ia) + int'(ib));
            r.s2 = (WCD+1)'(int'(ic) + int'(id));
            r.s3 = (WCD+2)'(int'(ia) + int'(ib) + int'(ic) + int'(id));
            sbq.push_back(r);
        end
        @(posedge clk);
        #1;
        if (rn !== 1'b1) begin
            ev1 = 1'b0;
            ev2 = 1'b0;
            sbq.delete();
        end else begin
            ev2 = ev1;
            ev1 = (v === 1'b1);
        end
    endtask

    task automatic test_reset();
        result_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd7, 4'd9, 8'd100, 8'd200, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_valid got %b want 0", out_valid);
            end
            e = '0;
            checks++;
            if ({sum1, sum2, sum3} !== e) begin
                failures++;
                $display("[TB] FAIL reset_sums got %0d/%0d/%0d want 0/0/0", sum1, sum2, sum3);
            end
        end
    endtask

    task automatic test_single();
        result_t e;
        step(1'b1, 4'd0, 4'd3, 8'd1, 8'd255, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
            checks++;
            if (out_valid !== ev2) begin
                failures++;
                $display("[TB] FAIL single_valid cycle %0d got %b want %b", i, out_valid, ev2);
            end
            if (ev2) begin
                e = sbq.pop_front();
                checks++;
                if (sum1 !== 5'd3 || sum2 !== 9'd256 || sum3 !== 10'd259 || e.s3 !== 10'd259) begin
                    failures++;
                    $display("[TB] FAIL single_sums got %0d/%0d/%0d want 3/256/259", sum1, sum2, sum3);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        result_t e;
        logic [WAB-1:0] ta [6] = '{4'd10, 4'd15, 4'd0, 4'd15, 4'd0, 4'd0};
        logic [WAB-1:0] tb [6] = '{4'd13, 4'd15, 4'd9, 4'd15, 4'd0, 4'd0};
        logic [WCD-1:0] tc [6] = '{8'd9, 8'd109, 8'd45, 8'd255, 8'd0, 8'd0};
        logic [WCD-1:0] td [6] = '{8'd10, 8'd37, 8'd45, 8'd255, 8'd0, 8'd0};
        for (int i = 0; i < 8; i++) begin
            if (i < 5)
                step(1'b1, ta[i], tb[i], tc[i], td[i], 1'b1);
            else
                step(1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 1'b1);
            checks++;
            if (out_valid !== ev2) begin
                failures++;
                $display("[TB] FAIL b2b_valid cycle %0d got %b want %b", i, out_valid, ev2);
            end
            if (ev2 && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({sum1, sum2, sum3} !== e) begin
                    failures++;
                    $display("[TB] FAIL b2b_sums cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             i, sum1, sum2, sum3, e.s1, e.s2, e.s3);
                end
            end
        end
    endtask

    task automatic test_bubble();
        result_t e;
        logic pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (pat[i])
                step(1'b1, 4'(i + 2), 4'(i + 5), 8'(i * 30), 8'(250 - i), 1'b1);
            else
                step(1'b0, 'x, 'x, 'x, 'x, 1'b1);
            checks++;
            if (out_valid !== ev2) begin
                failures++;
                $display("[TB] FAIL bubble_valid cycle %0d got %b want %b", i, out_valid, ev2);
            end
            if (ev2 && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({sum1, sum2, sum3} !== e) begin
                    failures++;
                    $display("[TB] FAIL bubble_sums cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             i, sum1, sum2, sum3, e.s1, e.s2, e.s3);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        result_t e;
        logic           vv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic           rr [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic           ov [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(vv[i], 4'(3 + i), 4'(11 - i), 8'(17 * i), 8'(201 + i), rr[i]);
            checks++;
            if (out_valid !== ov[i] || out_valid !== ev2) begin
                failures++;
                $display("[TB] FAIL midreset_valid cycle %0d got %b want %b", i, out_valid, ov[i]);
            end
            if (rr[i] === 1'b0) begin
                checks++;
                if (sum1 !== '0 || sum2 !== '0 || sum3 !== '0) begin
                    failures++;
                    $display("[TB] FAIL midreset_sums cycle %0d got %0d/%0d/%0d want 0/0/0",
                             i, sum1, sum2, sum3);
                end
            end
            if (ev2 && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({sum1, sum2, sum3} !== e) begin
                    failures++;
                    $display("[TB] FAIL midreset_out cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             i, sum1, sum2, sum3, e.s1, e.s2, e.s3);
                end
            end
        end
    endtask

    task automatic test_random();
        result_t e;
        logic v;
        for (int i = 0; i < 10002; i++) begin
            v = (i < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            step(v, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            checks++;
            if (out_valid !== ev2) begin
                failures++;
                $display("[TB] FAIL random_valid cycle %0d got %b want %b", i, out_valid, ev2);
            end
            if (ev2 && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({sum1, sum2, sum3} !== e) begin
                    failures++;
                    $display("[TB] FAIL random_sums cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             i, sum1, sum2, sum3, e.s1, e.s2, e.s3);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL random_drain got %0d pending want 0", sbq.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_bubble();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
